servo_pwm_sweep: RTL and testbench

- Multi-channel servo PWM generator for the radar scan head, with one shared period counter and N_CH independent duty channels.
- Period and duty are taken in scaled command units and converted to clock cycles internally.
- Duty and period updates are double-buffered and take effect only at a frame boundary, so every output pulse is glitch-free.
- Channel 0 has an optional autonomous sweep mode that ramps its duty back and forth between two limits, so the radar sensor pans without CPU intervention.

---
 rtl/servo_pwm_sweep.sv | 145 ++++++++++++++
 tb/tb_servo_pwm_sweep.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_sweep.sv
// Multi-channel servo PWM with a shared period counter, frame-aligned shadow
// registers for period/duty, and an autonomous back-and-forth sweep on channel 0.
module servo_pwm_sweep #(
    parameter int N_CH         = 2,
    parameter int PERIOD_W     = 20,
    parameter int DUTY_W       = 16,
    parameter int PERIOD_SCALE = 1000,
    parameter int DUTY_SCALE   = 100,
    parameter int SWEEP_MIN    = 5000,
    parameter int SWEEP_MAX    = 25000,
    parameter int SWEEP_STEP   = 500,
    parameter int SWEEP_DIV    = 2,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [7:0]        cfg_period_i,
    input  logic              duty_we_i,
    input  logic [CH_W-1:0]   duty_ch_i,
    input  logic [7:0]        duty_in_i,
    input  logic              sweep_en_i,
    output logic [N_CH-1:0]   pwm_o,
    output logic              frame_o,
    output logic [DUTY_W-1:0] sweep_duty_o,
    output logic              sweep_dir_o
);

    localparam int CW    = (PERIOD_W > DUTY_W) ? PERIOD_W : DUTY_W;
    localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

    localparam logic [PERIOD_W-1:0] ONE_P   = PERIOD_W'(1);
    localparam logic [DIV_W-1:0]    ONE_DIV = DIV_W'(1);
    localparam logic [DIV_W-1:0]    DIV_END = DIV_W'(SWEEP_DIV - 1);
    localparam logic [DUTY_W-1:0]   MIN_D   = DUTY_W'(SWEEP_MIN);
    localparam logic [DUTY_W-1:0]   MAX_D   = DUTY_W'(SWEEP_MAX);
    localparam logic [DUTY_W-1:0]   STEP_D  = DUTY_W'(SWEEP_STEP);
    localparam logic [DUTY_W:0]     MIN_X   = (DUTY_W+1)'(SWEEP_MIN);
    localparam logic [DUTY_W:0]     MAX_X   = (DUTY_W+1)'(SWEEP_MAX);
    localparam logic [DUTY_W:0]     STEP_X  = (DUTY_W+1)'(SWEEP_STEP);

    // Sweep direction doubles as the sweep FSM state.
    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } sweep_state_e;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_pend_q, period_act_q;
    logic [DUTY_W-1:0]   duty_pend_q [N_CH];
    logic [DUTY_W-1:0]   duty_act_q  [N_CH];
    logic [N_CH-1:0]     pwm_q;
    logic                frame_q;
    sweep_state_e        state_q, state_d;
    logic [DUTY_W-1:0]   sweep_duty_q, sweep_duty_d;
    logic [DIV_W-1:0]    div_q, div_d;

    logic             idle, wrap, load, step;
    logic [DUTY_W:0]  up_sum, dn_lim;

    assign idle   = (period_act_q == '0);
    assign wrap   = !idle && (cnt_q == period_act_q - ONE_P);
    // While idle the shadow registers reload every cycle so a new period starts at once.
    assign load   = wrap || idle;
    assign step   = wrap && sweep_en_i && (div_q == DIV_END);
    assign cnt_d  = load ? '0 : cnt_q + ONE_P;
    assign up_sum = {1'b0, sweep_duty_q} + STEP_X;
    assign dn_lim = MIN_X + STEP_X;

    always_comb begin
        state_d      = state_q;
        sweep_duty_d = sweep_duty_q;
        div_d        = div_q;
        if (load) begin
            if (!sweep_en_i) begin
                state_d      = UP;
                sweep_duty_d = MIN_D;
                div_d        = '0;
            end else if (step) begin
                div_d = '0;
                if (state_q == UP) begin
                    if (up_sum >= MAX_X) begin
                        sweep_duty_d = MAX_D;
                        state_d      = DOWN;
                    end else begin
                        sweep_duty_d = up_sum[DUTY_W-1:0];
                    end
                end else begin
                    if ({1'b0, sweep_duty_q} <= dn_lim) begin
                        sweep_duty_d = MIN_D;
                        state_d      = UP;
                    end else begin
                        sweep_duty_d = sweep_duty_q - STEP_D;
                    end
                end
            end else if (wrap) begin
                div_d = div_q + ONE_DIV;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            period_pend_q <= '0;
            period_act_q  <= '0;
            pwm_q         <= '0;
            frame_q       <= 1'b0;
            state_q       <= UP;
            sweep_duty_q  <= MIN_D;
            div_q         <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_pend_q[i] <= '0;
                duty_act_q[i]  <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            sweep_duty_q <= sweep_duty_d;
            div_q        <= div_d;
            frame_q      <= !idle && (cnt_q == '0);
            if (cfg_we_i) begin
                period_pend_q <= PERIOD_W'(32'(cfg_period_i) * 32'(PERIOD_SCALE));
            end
            if (load) begin
                period_act_q <= period_pend_q;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (duty_we_i && (duty_ch_i == CH_W'(i))) begin
                    duty_pend_q[i] <= DUTY_W'(32'(duty_in_i) * 32'(DUTY_SCALE));
                end
                if (load) begin
                    duty_act_q[i] <= (i == 0 && sweep_en_i) ? sweep_duty_d : duty_pend_q[i];
                end
                pwm_q[i] <= !idle && (CW'(cnt_q) < CW'(duty_act_q[i]));
            end
        end
    end

    assign pwm_o        = pwm_q;
    assign frame_o      = frame_q;
    assign sweep_duty_o = sweep_duty_q;
    assign sweep_dir_o  = (state_q == UP);

endmodule

// File: tb/tb_servo_pwm_sweep.sv
// Directed bench for servo_pwm_sweep: period 10 cycles/unit, duty 1 cycle/unit,
// sweep 5..15 step 4 every frame; per-frame high-times measured against hand values.
module tb_servo_pwm_sweep;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [7:0]  cfg_period_i;
    logic        duty_we_i;
    logic [0:0]  duty_ch_i;
    logic [7:0]  duty_in_i;
    logic        sweep_en_i;
    logic [1:0]  pwm_o;
    logic        frame_o;
    logic [15:0] sweep_duty_o;
    logic        sweep_dir_o;

    int n_cmp = 0;
    int n_err = 0;
    int r_hi0, r_hi1, r_nfr, r_sd;
    logic [1:0] r_first;
    logic r_fend, r_dir, r_seen;

    servo_pwm_sweep #(
        .N_CH(2), .PERIOD_W(20), .DUTY_W(16), .PERIOD_SCALE(10), .DUTY_SCALE(1),
        .SWEEP_MIN(5), .SWEEP_MAX(15), .SWEEP_STEP(4), .SWEEP_DIV(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_period_i(cfg_period_i),
        .duty_we_i(duty_we_i), .duty_ch_i(duty_ch_i), .duty_in_i(duty_in_i),
        .sweep_en_i(sweep_en_i), .pwm_o(pwm_o), .frame_o(frame_o),
        .sweep_duty_o(sweep_duty_o), .sweep_dir_o(sweep_dir_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int p);
        cfg_we_i = 1'b1; cfg_period_i = 8'(p);
        @(negedge clk_i);
        cfg_we_i = 1'b0;
    endtask

    task automatic duty_write(input int ch, input int d);
        duty_we_i = 1'b1; duty_ch_i = 1'(ch); duty_in_i = 8'(d);
        @(negedge clk_i);
        duty_we_i = 1'b0;
    endtask

    task automatic wait_frame();
        r_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (frame_o === 1'b1) begin
                r_seen = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    // Count frames and pwm highs over a window with no frame expected.
    task automatic idle_window(input string tag, input int len);
        int nfr, hi;
        nfr = 0; hi = 0;
        for (int k = 0; k < len; k++) begin
            nfr += int'(frame_o);
            hi  += int'(pwm_o[0]) + int'(pwm_o[1]);
            @(negedge clk_i);
        end
        check({tag, " frames"}, nfr, 0);
        check({tag, " pwm_high"}, hi, 0);
    endtask

    // Measure one frame starting at its frame pulse; optionally drive one write at sample wk.
    // wkind: 1 duty write, 2 period write, 3 set sweep_en to wval.
    task automatic frame_check(input string tag, input int len, input int wk, input int wkind,
                               input int wch, input int wval, input int e_hi0, input int e_hi1,
                               input int e_fend, input int e_sd, input int e_dir);
        wait_frame();
        check({tag, " frame_seen"}, r_seen, 1);
        r_hi0 = 0; r_hi1 = 0; r_nfr = 0;
        r_first = pwm_o; r_sd = int'(sweep_duty_o); r_dir = sweep_dir_o;
        for (int k = 0; k < len; k++) begin
            r_hi0 += int'(pwm_o[0]);
            r_hi1 += int'(pwm_o[1]);
            r_nfr += int'(frame_o);
            duty_we_i = 1'b0;
            cfg_we_i  = 1'b0;
            if (k == wk) begin
                case (wkind)
                    1: begin duty_we_i = 1'b1; duty_ch_i = 1'(wch); duty_in_i = 8'(wval); end
                    2: begin cfg_we_i = 1'b1; cfg_period_i = 8'(wval); end
                    3: sweep_en_i = wval[0];
                    default: ;
                endcase
            end
            @(negedge clk_i);
        end
        duty_we_i = 1'b0;
        cfg_we_i  = 1'b0;
        r_fend = frame_o;
        check({tag, " hi0"}, r_hi0, e_hi0);
        check({tag, " hi1"}, r_hi1, e_hi1);
        check({tag, " nframes"}, r_nfr, 1);
        check({tag, " next_frame"}, r_fend, e_fend);
        check({tag, " first0"}, r_first[0], e_hi0 != 0);
        check({tag, " first1"}, r_first[1], e_hi1 != 0);
        check({tag, " sweep_duty"}, r_sd, e_sd);
        check({tag, " sweep_dir"}, r_dir, e_dir);
    endtask

    initial begin
        int sweep_seq [7] = '{9, 13, 15, 11, 7, 5, 9};
        int dir_seq   [7] = '{1, 1, 0, 0, 0, 1, 1};
        rst_i = 1'b1; cfg_we_i = 1'b0; cfg_period_i = '0; duty_we_i = 1'b0;
        duty_ch_i = '0; duty_in_i = '0; sweep_en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst pwm", pwm_o, 0);
        check("rst frame", frame_o, 0);
        check("rst sweep_duty", sweep_duty_o, 5);
        check("rst sweep_dir", sweep_dir_o, 1);

        // Writes, a few running cycles, then a one-cycle reset wipes everything.
        duty_write(1, 10);
        cfg_write(4);
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst2 pwm", pwm_o, 0);
        check("rst2 frame", frame_o, 0);
        idle_window("rst2 idle", 100);

        // Duty first so it is in place when the period loads.
        duty_write(1, 10);
        cfg_write(4);
        frame_check("P40a", 40, -1, 0, 0, 0, 0, 10, 1, 5, 1);
        frame_check("P40b", 40, -1, 0, 0, 0, 0, 10, 1, 5, 1);
        frame_check("A", 40, 15, 1, 1, 30, 0, 10, 1, 5, 1);
        frame_check("B", 40, 38, 2, 0, 6, 0, 30, 1, 5, 1);
        frame_check("C", 40, -1, 0, 0, 0, 0, 30, 1, 5, 1);
        frame_check("D", 60, 10, 2, 0, 4, 0, 30, 1, 5, 1);
        frame_check("E", 40, 5, 1, 1, 50, 0, 30, 1, 5, 1);
        frame_check("F", 40, 5, 1, 1, 0, 0, 40, 1, 5, 1);
        frame_check("G", 40, 5, 1, 1, 50, 0, 0, 1, 5, 1);
        frame_check("H", 40, 5, 2, 0, 0, 0, 40, 0, 5, 1);
        idle_window("stopped", 100);

        // Sweep: ch1 still has duty 50 against period 40, so it stays high.
        cfg_write(4);
        frame_check("S0", 40, 5, 3, 0, 1, 0, 40, 1, 5, 1);
        for (int s = 0; s < 7; s++) begin
            if (s == 5)
                frame_check($sformatf("S%0d", s + 1), 40, 5, 1, 0, 20, sweep_seq[s], 40, 1,
                            sweep_seq[s], dir_seq[s]);
            else if (s == 6)
                frame_check($sformatf("S%0d", s + 1), 40, 5, 3, 0, 0, sweep_seq[s], 40, 1,
                            sweep_seq[s], dir_seq[s]);
            else
                frame_check($sformatf("S%0d", s + 1), 40, -1, 0, 0, 0, sweep_seq[s], 40, 1,
                            sweep_seq[s], dir_seq[s]);
        end
        frame_check("S8", 40, -1, 0, 0, 0, 20, 40, 1, 5, 1);

        // Reset in the middle of a frame.
        wait_frame();
        check("mid frame_seen", r_seen, 1);
        repeat (10) @(negedge clk_i);
        check("mid pwm", pwm_o, 3);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst pwm", pwm_o, 0);
        check("midrst frame", frame_o, 0);
        check("midrst sweep_duty", sweep_duty_o, 5);
        check("midrst sweep_dir", sweep_dir_o, 1);
        idle_window("midrst idle", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
